// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and defaults for the FIFO write arbiter.
package fifo_arb_pkg;
  typedef enum logic {IDLE, OWN} arb_state_e;
  localparam int NREQ_D = 4;
  localparam int DW_D = 8;
  localparam int BURST_LEN_D = 4;
  localparam int CNT_W = 16;
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshake and FIFO write-side signals of the arbiter.
interface fifo_wr_arbiter_if import fifo_arb_pkg::*; #(parameter int NREQ = NREQ_D, parameter int DW = DW_D);
  logic [NREQ-1:0] req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] grant;
  logic busy;
  logic fifo_wr_en;
  logic [DW-1:0] fifo_data_in;
  logic fifo_full;
  modport master (input req_valid, req_data, fifo_full, output req_ready, grant, busy, fifo_wr_en, fifo_data_in);
  modport slave (output req_valid, req_data, fifo_full, input req_ready, grant, busy, fifo_wr_en, fifo_data_in);
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// fifo_arb_rr_pick: combinational round-robin picker searching upward from last+1.
module fifo_arb_rr_pick import fifo_arb_pkg::*; #(
  parameter int NREQ = NREQ_D,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   idx,
  output logic            any
);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};
  always_comb begin
    idx = '0;
    for (int i = NREQ; i >= 1; i--)
      if (req[(int'(last) + i) % NREQ]) idx = IW'((int'(last) + i) % NREQ);
    any = |req;
    win = any ? ONE << idx : '0;
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst-limited arbiter sharing one FIFO write port.
// Optional per-requester beat and stall statistics under FIFO_ARB_STATS_EN.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int NREQ = NREQ_D,
  parameter int DW = DW_D,
  parameter int BURST_LEN = BURST_LEN_D
) (
  input logic clk,
  input logic rstn,
  fifo_wr_arbiter_if.master bus
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0] beat_count,
  output logic [CNT_W-1:0] stall_cycles
`endif
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST_LEN + 1);
  arb_state_e state, state_nxt;
  logic [IW-1:0] owner, last_owner, pick_idx;
  logic [NREQ-1:0] pick_win, grant_q;
  logic [CW-1:0] beat_cnt;
  logic pick_any, own, own_valid, beat, rel;
  fifo_arb_rr_pick #(.NREQ(NREQ)) u_pick (
    .req(bus.req_valid), .last(last_owner), .win(pick_win), .idx(pick_idx), .any(pick_any)
  );
  assign own = state == OWN;
  assign own_valid = bus.req_valid[owner];
  assign beat = own & own_valid & !bus.fifo_full;
  // A dropped valid forfeits the grant even while the FIFO is full.
  assign rel = own & (!own_valid | (beat & beat_cnt == CW'(BURST_LEN - 1)));
  always_comb state_nxt = own ? (rel ? IDLE : OWN) : (pick_any ? OWN : IDLE);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      owner <= '0;
      last_owner <= IW'(NREQ - 1);
      beat_cnt <= '0;
      grant_q <= '0;
    end else if (!own) begin
      if (pick_any) begin
        owner <= pick_idx;
        grant_q <= pick_win;
        beat_cnt <= '0;
      end
    end else if (rel) begin
      last_owner <= owner;
      grant_q <= '0;
    end else if (beat) beat_cnt <= beat_cnt + CW'(1);
  assign bus.grant = grant_q;
  assign bus.busy = own;
  assign bus.fifo_wr_en = beat;
  assign bus.req_ready = (own & !bus.fifo_full) ? grant_q : '0;
  assign bus.fifo_data_in = own ? bus.req_data[int'(owner)*DW +: DW] : '0;
`ifdef FIFO_ARB_STATS_EN
  logic [CNT_W-1:0] bc [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) bc[g] <= '0;
      else if (beat && owner == IW'(g) && bc[g] != '1) bc[g] <= bc[g] + CNT_W'(1);
    assign beat_count[g*CNT_W +: CNT_W] = bc[g];
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) stall_cycles <= '0;
    else if (own && own_valid && bus.fifo_full && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter (NREQ=4, DW=8, BURST_LEN=4).
module tb_fifo_wr_arbiter;
  logic clk = 0;
  logic rstn = 0;
  int tests = 0;
  int fails = 0;
  fifo_wr_arbiter_if #(.NREQ(4), .DW(8)) bif ();
`ifdef FIFO_ARB_STATS_EN
  logic [63:0] beat_count;
  logic [15:0] stall_cycles;
`endif
  fifo_wr_arbiter #(.NREQ(4), .DW(8), .BURST_LEN(4)) dut (
    .clk(clk), .rstn(rstn), .bus(bif)
`ifdef FIFO_ARB_STATS_EN
    , .beat_count(beat_count), .stall_cycles(stall_cycles)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic lane(input int i, input logic [7:0] v);
    bif.req_data[i*8 +: 8] = v;
  endtask
  task automatic do_reset();
    bif.req_valid = '0;
    bif.fifo_full = 0;
    rstn = 0;
    tick();
    rstn = 1;
    #1;
  endtask
  int seq [5] = '{0, 1, 2, 3, 0};
  initial begin
    bif.req_data = '0;
    do_reset();
    chk("rst_grant", 32'(bif.grant), 0);
    chk("rst_busy", 32'(bif.busy), 0);
    chk("rst_wr_en", 32'(bif.fifo_wr_en), 0);
    chk("rst_ready", 32'(bif.req_ready), 0);
    // single requester
    bif.req_valid = 4'b0001;
    lane(0, 8'h11);
    #1;
    chk("single_idle_wr", 32'(bif.fifo_wr_en), 0);
    chk("single_idle_data", 32'(bif.fifo_data_in), 0);
    tick();
    chk("single_grant", 32'(bif.grant), 4'b0001);
    chk("single_ready", 32'(bif.req_ready), 4'b0001);
    for (int k = 0; k < 3; k++) begin
      lane(0, 8'(8'h11 * (k + 1)));
      #1;
      chk("single_wr", 32'(bif.fifo_wr_en), 1);
      chk("single_data", 32'(bif.fifo_data_in), 32'(8'h11 * (k + 1)));
      tick();
    end
    bif.req_valid = '0;
    #1;
    chk("single_drop_wr", 32'(bif.fifo_wr_en), 0);
    chk("single_drop_busy", 32'(bif.busy), 1);
    tick();
    chk("single_rel_grant", 32'(bif.grant), 0);
    chk("single_rel_busy", 32'(bif.busy), 0);
    // burst cap, then re-grant to the same requester after one bubble
    bif.req_valid = 4'b0010;
    lane(1, 8'hA0);
    tick();
    chk("burst_grant", 32'(bif.grant), 4'b0010);
    for (int k = 0; k < 4; k++) begin
      lane(1, 8'(8'hA0 + k));
      #1;
      chk("burst_wr", 32'(bif.fifo_wr_en), 1);
      chk("burst_data", 32'(bif.fifo_data_in), 32'(8'hA0 + k));
      tick();
    end
    lane(1, 8'hA4);
    #1;
    chk("burst_bubble_grant", 32'(bif.grant), 0);
    chk("burst_bubble_wr", 32'(bif.fifo_wr_en), 0);
    tick();
    chk("burst_regrant", 32'(bif.grant), 4'b0010);
    for (int k = 4; k < 6; k++) begin
      lane(1, 8'(8'hA0 + k));
      #1;
      chk("burst2_data", 32'(bif.fifo_data_in), 32'(8'hA0 + k));
      chk("burst2_wr", 32'(bif.fifo_wr_en), 1);
      tick();
    end
    bif.req_valid = '0;
    #1;
    chk("burst2_drop_wr", 32'(bif.fifo_wr_en), 0);
    tick();
    chk("burst2_rel", 32'(bif.grant), 0);
    // round robin from reset
    do_reset();
    bif.req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 4; i++) lane(i, 8'(i * 16));
      #1;
      chk("rr_idle", 32'(bif.grant), 0);
      tick();
      chk("rr_grant", 32'(bif.grant), 32'(1) << seq[n]);
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < 4; i++) lane(i, 8'(i * 16 + k));
        #1;
        chk("rr_wr", 32'(bif.fifo_wr_en), 1);
        chk("rr_data", 32'(bif.fifo_data_in), 32'(seq[n] * 16 + k));
        tick();
      end
`ifdef FIFO_ARB_STATS_EN
      if (n == 3) chk("stats_beats", 32'(beat_count[31:0] ^ beat_count[63:32]), 0);
      if (n == 3) chk("stats_beat0", 32'(beat_count[15:0]), 4);
      if (n == 3) chk("stats_beat3", 32'(beat_count[63:48]), 4);
`endif
    end
    // full stall mid-burst of req 2
    do_reset();
    bif.req_valid = 4'b0100;
    lane(2, 8'hC0);
    tick();
    chk("full_grant", 32'(bif.grant), 4'b0100);
    for (int k = 0; k < 2; k++) begin
      lane(2, 8'(8'hC0 + k));
      #1;
      chk("full_pre_data", 32'(bif.fifo_data_in), 32'(8'hC0 + k));
      tick();
    end
    lane(2, 8'hC2);
    bif.fifo_full = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("full_wr", 32'(bif.fifo_wr_en), 0);
      chk("full_ready", 32'(bif.req_ready), 0);
      chk("full_grant_held", 32'(bif.grant), 4'b0100);
      tick();
    end
    bif.fifo_full = 0;
    #1;
    chk("resume_wr", 32'(bif.fifo_wr_en), 1);
    chk("resume_data", 32'(bif.fifo_data_in), 8'hC2);
    tick();
    lane(2, 8'hC3);
    #1;
    chk("resume_last_wr", 32'(bif.fifo_wr_en), 1);
    tick();
    chk("resume_rel", 32'(bif.grant), 0);
    bif.req_valid = '0;
    // reset mid-burst of req 3
    do_reset();
    bif.req_valid = 4'b1000;
    lane(3, 8'hD0);
    tick();
    chk("rstmid_grant", 32'(bif.grant), 4'b1000);
    tick();
    lane(3, 8'hD1);
    #1;
    chk("rstmid_wr", 32'(bif.fifo_wr_en), 1);
    rstn = 0;
    #1;
    chk("rstmid_grant0", 32'(bif.grant), 0);
    chk("rstmid_wr0", 32'(bif.fifo_wr_en), 0);
    chk("rstmid_ready0", 32'(bif.req_ready), 0);
    bif.req_valid = 4'hF;
    #1;
    rstn = 1;
    tick();
    chk("rstmid_first", 32'(bif.grant), 4'b0001);
`ifdef FIFO_ARB_STATS_EN
    do_reset();
    bif.req_valid = 4'b0001;
    tick();
    bif.fifo_full = 1;
    for (int k = 0; k < 5; k++) tick();
    bif.fifo_full = 0;
    #1;
    chk("stats_stall", 32'(stall_cycles), 5);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $fatal(1, "FAIL timeout: run did not finish");
  end
endmodule
